// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_stage_pkg
// Purpose  : Shared types and constants for the instruction-fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package if_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } if_state_e;

  localparam int unsigned C_IF_TO_ID_BUS_W = 65;
  localparam logic [31:0] C_NOP_INST       = 32'h0000_0000;

  // IF-to-ID bus layout, MSB first: {ex, pc[31:0], inst[31:0]}
  function automatic logic [C_IF_TO_ID_BUS_W-1:0] pack_if_to_id(
    input logic        ex,
    input logic [31:0] pc,
    input logic [31:0] inst
  );
    return {ex, pc, inst};
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_inst_buf.sv
`default_nettype none
// ============================================================================
// Module   : if_inst_buf
// Purpose  : Holding register for an instruction word that ID could not take
//            in the cycle it arrived from the instruction SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module if_inst_buf
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        ld_i,
  input  logic [31:0] d_i,
  output logic [31:0] q_o
);

  logic [31:0] buf_q;
  logic [31:0] buf_d;

  // Clear wins over load so a flush in the capture cycle leaves nothing behind.
  always_comb begin
    buf_d = buf_q;
    if (clr_i) begin
      buf_d = C_NOP_INST;
    end else if (ld_i) begin
      buf_d = d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= C_NOP_INST;
    end else begin
      buf_q <= buf_d;
    end
  end

  assign q_o = buf_q;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Purpose  : Instruction-fetch stage; pairs the SRAM read data with its PC and
//            hands it to ID, buffering it while ID stalls.
// Options  : IF_ADEF_CHECK_EN - flag misaligned fetch PCs as ADEF.
// Revision : 1.0 - initial release
// ============================================================================
module if_stage
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        pre_if_ready_go,
  input  logic [31:0] if_pc,
  input  logic [31:0] inst_rdata,
  input  logic        id_allow_in,
  input  logic        br_taken,
  input  logic        wb_ex,
  output logic        if_allow_in,
  output logic        if_to_id_valid,
  output logic [31:0] if_to_id_pc,
  output logic [31:0] if_to_id_inst,
  output logic        if_to_id_ex
);

  if_state_e state_q;

  logic        w_flush;
  logic        w_accept;
  logic        w_valid;
  logic        w_adef;
  logic        w_buf_ld;
  logic        w_buf_clr;
  logic [31:0] w_buf_q;
  logic [31:0] w_inst_sel;
  logic [31:0] w_inst;
  logic [C_IF_TO_ID_BUS_W-1:0] w_bus;

  assign w_flush     = br_taken | wb_ex;
  assign if_allow_in = (state_q == ST_EMPTY) | (id_allow_in & ~w_flush);
  assign w_accept    = pre_if_ready_go & if_allow_in & ~w_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else if (w_flush) begin
      state_q <= ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: state_q <= w_accept ? ST_FETCH : ST_EMPTY;
        ST_FETCH,
        ST_HOLD: begin
          if (id_allow_in) begin
            state_q <= w_accept ? ST_FETCH : ST_EMPTY;
          end else begin
            state_q <= ST_HOLD;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  // SRAM data is only present in the FETCH cycle, so capture it there if ID stalls.
  assign w_buf_ld  = (state_q == ST_FETCH) & ~id_allow_in & ~w_flush;
  assign w_buf_clr = w_flush;

  if_inst_buf u_inst_buf (
    .clk   (clk),
    .rst   (rst),
    .clr_i (w_buf_clr),
    .ld_i  (w_buf_ld),
    .d_i   (inst_rdata),
    .q_o   (w_buf_q)
  );

  assign w_valid    = ~rst & (state_q != ST_EMPTY) & ~w_flush;
  assign w_inst_sel = (state_q == ST_HOLD) ? w_buf_q : inst_rdata;

`ifdef IF_ADEF_CHECK_EN
  assign w_adef = w_valid & (if_pc[1:0] != 2'b00);
`else
  assign w_adef = 1'b0;
`endif

  assign w_inst = (rst | w_adef) ? C_NOP_INST : w_inst_sel;
  assign w_bus  = pack_if_to_id(w_adef, if_pc, w_inst);

  assign if_to_id_valid = w_valid;
  assign if_to_id_ex    = w_bus[C_IF_TO_ID_BUS_W-1];
  assign if_to_id_pc    = w_bus[63:32];
  assign if_to_id_inst  = w_bus[31:0];

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Purpose  : Self-checking bench for if_stage: slot-occupancy reference model
//            plus directed scenarios with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;

`ifdef IF_ADEF_CHECK_EN
  localparam bit ADEF_ON = 1'b1;
`else
  localparam bit ADEF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pre = 1'b0;
  logic [31:0] pc = 32'h0;
  logic [31:0] rdata = 32'h0;
  logic        idal = 1'b0;
  logic        br = 1'b0;
  logic        wbex = 1'b0;
  logic        allow_o, valid_o, ex_o;
  logic [31:0] pc_o, inst_o;

  always #5 clk = ~clk;

  if_stage dut (
    .clk             (clk),
    .rst             (rst),
    .pre_if_ready_go (pre),
    .if_pc           (pc),
    .inst_rdata      (rdata),
    .id_allow_in     (idal),
    .br_taken        (br),
    .wb_ex           (wbex),
    .if_allow_in     (allow_o),
    .if_to_id_valid  (valid_o),
    .if_to_id_pc     (pc_o),
    .if_to_id_inst   (inst_o),
    .if_to_id_ex     (ex_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one instruction slot; data either still on the SRAM bus
  // (not yet known) or already captured.
  bit          m_live = 1'b0;
  bit          m_full = 1'b0;
  bit          m_known = 1'b0;
  bit          m_room;
  logic [31:0] m_data = 32'h0;

  always @(posedge clk) begin
    if (rst) begin
      m_live  = 1'b1;
      m_full  = 1'b0;
      m_known = 1'b0;
      m_data  = 32'h0;
    end else if (br || wbex) begin
      m_full  = 1'b0;
      m_known = 1'b0;
    end else begin
      m_room = !m_full || idal;
      if (m_full && !idal && !m_known) begin
        m_known = 1'b1;
        m_data  = rdata;
      end
      if (pre && m_room) begin
        m_full  = 1'b1;
        m_known = 1'b0;
      end else if (m_full && idal) begin
        m_full  = 1'b0;
        m_known = 1'b0;
      end
    end
  end

  bit          e_valid, e_allow, e_ex, e_flush;
  logic [31:0] e_inst;

  always @(negedge clk) begin
    if (m_live) begin
      e_flush = br || wbex;
      e_valid = !rst && m_full && !e_flush;
      e_allow = !m_full || (idal && !e_flush);
      e_ex    = ADEF_ON && e_valid && (pc[1:0] != 2'b00);
      e_inst  = m_known ? m_data : rdata;
      if (e_ex) e_inst = 32'h0;
      chk("m_valid", {31'h0, valid_o}, {31'h0, e_valid});
      chk("m_allow", {31'h0, allow_o}, {31'h0, e_allow});
      chk("m_ex", {31'h0, ex_o}, {31'h0, e_ex});
      if (rst) begin
        chk("m_rst_inst", inst_o, 32'h0);
      end else if (e_valid) begin
        chk("m_inst", inst_o, e_inst);
        chk("m_pc", pc_o, pc);
      end
    end
  end

  task automatic drive(input bit r, input bit p, input logic [31:0] pcv, input logic [31:0] rd,
                       input bit ia, input bit b, input bit e);
    @(posedge clk);
    #1;
    rst = r; pre = p; pc = pcv; rdata = rd; idal = ia; br = b; wbex = e;
    @(negedge clk);
    #1;
  endtask

  initial begin
    // reset
    drive(1, 0, 32'h0, 32'hdead_beef, 1, 0, 0);
    chk("rst_valid", {31'h0, valid_o}, 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_ex", {31'h0, ex_o}, 32'h0);
    // steady flow
    drive(0, 1, 32'h0, 32'h1111_1111, 1, 0, 0);
    chk("idle_valid", {31'h0, valid_o}, 32'h0);
    drive(0, 1, 32'h1c00_0000, 32'ha000_0000, 1, 0, 0);
    chk("flow0_valid", {31'h0, valid_o}, 32'h1);
    chk("flow0_inst", inst_o, 32'ha000_0000);
    drive(0, 1, 32'h1c00_0004, 32'ha000_0001, 1, 0, 0);
    chk("flow1_inst", inst_o, 32'ha000_0001);
    chk("flow1_pc", pc_o, 32'h1c00_0004);
    drive(0, 0, 32'h1c00_0008, 32'ha000_0002, 1, 0, 0);
    chk("flow2_valid", {31'h0, valid_o}, 32'h1);
    chk("flow2_inst", inst_o, 32'ha000_0002);
    drive(0, 1, 32'h1c00_0008, 32'h2222_2222, 1, 0, 0);
    chk("bubble_valid", {31'h0, valid_o}, 32'h0);
    // stall into HOLD
    drive(0, 1, 32'h1c00_000c, 32'h0280_0421, 0, 0, 0);
    chk("stall_allow", {31'h0, allow_o}, 32'h0);
    drive(0, 1, 32'h1c00_000c, 32'h3333_3333, 0, 0, 0);
    chk("hold_inst", inst_o, 32'h0280_0421);
    chk("hold_allow", {31'h0, allow_o}, 32'h0);
    drive(0, 1, 32'h1c00_000c, 32'h4444_4444, 0, 0, 0);
    chk("hold2_inst", inst_o, 32'h0280_0421);
    drive(0, 1, 32'h1c00_000c, 32'h5555_5555, 1, 0, 0);
    chk("release_inst", inst_o, 32'h0280_0421);
    chk("release_valid", {31'h0, valid_o}, 32'h1);
    // branch flush while holding
    drive(0, 0, 32'h1c00_0010, 32'hb000_0000, 0, 0, 0);
    drive(0, 0, 32'h1c00_0010, 32'h6666_6666, 0, 1, 0);
    chk("br_valid", {31'h0, valid_o}, 32'h0);
    drive(0, 0, 32'h1c00_0010, 32'h7777_7777, 0, 0, 0);
    chk("br_empty_allow", {31'h0, allow_o}, 32'h1);
    chk("br_buf", dut.u_inst_buf.buf_q, 32'h0);
    // wb_ex together with br_taken
    drive(0, 1, 32'h1c00_0010, 32'h7777_7777, 1, 0, 0);
    drive(0, 1, 32'h1c00_0014, 32'hc000_0000, 1, 1, 1);
    chk("exbr_valid", {31'h0, valid_o}, 32'h0);
    chk("exbr_allow", {31'h0, allow_o}, 32'h0);
    drive(0, 0, 32'h1c00_0014, 32'h8888_8888, 0, 0, 0);
    chk("exbr_empty", {31'h0, allow_o}, 32'h1);
    chk("exbr_none", {31'h0, valid_o}, 32'h0);
    // misaligned fetch PC
    drive(0, 1, 32'h1c00_0014, 32'h8888_8888, 1, 0, 0);
    drive(0, 0, 32'h1c00_0002, 32'hd000_0000, 1, 0, 0);
    chk("adef_ex", {31'h0, ex_o}, {31'h0, ADEF_ON});
    chk("adef_inst", inst_o, ADEF_ON ? 32'h0 : 32'hd000_0000);
    // reset during HOLD
    drive(0, 1, 32'h1c00_0018, 32'h9999_9999, 1, 0, 0);
    drive(0, 0, 32'h1c00_0018, 32'he000_0000, 0, 0, 0);
    drive(1, 0, 32'h1c00_0018, 32'haaaa_aaaa, 0, 0, 0);
    chk("rsthold_valid", {31'h0, valid_o}, 32'h0);
    chk("rsthold_inst", inst_o, 32'h0);
    drive(0, 0, 32'h1c00_0018, 32'hbbbb_bbbb, 0, 0, 0);
    chk("postrst_valid", {31'h0, valid_o}, 32'h0);
    chk("postrst_allow", {31'h0, allow_o}, 32'h1);
    drive(0, 1, 32'h1c00_0018, 32'hbbbb_bbbb, 1, 0, 0);
    drive(0, 0, 32'h1c00_001c, 32'hf000_0000, 1, 0, 0);
    chk("fresh_inst", inst_o, 32'hf000_0000);
    chk("fresh_valid", {31'h0, valid_o}, 32'h1);
    // mixed traffic checked by the model alone
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0),
            ($urandom_range(0, 3) != 0),
            {$urandom(), 2'b00} | (($urandom_range(0, 7) == 0) ? 32'h2 : 32'h0),
            $urandom(),
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 15) == 0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have these ports, listed as name, direction, width, meaning:
- clk, in, 1, single clock, rising edge.
- rst, in, 1, reset; synchronous and active-high.
REQ-002 pre_if_ready_go, in, 1: the PC stage holds a valid address whose instruction data returns next cycle.
REQ-003 if_pc, in, 32: PC of the instruction currently in IF, from the PC register.
REQ-004 inst_rdata, in, 32: instruction SRAM read data.
- It is valid exactly one cycle after acceptance.
- It is not held afterwards.
REQ-005 id_allow_in, in, 1: ID can accept an instruction this cycle.
REQ-006 br_taken, in, 1: redirect from ID; flush request.
REQ-007 wb_ex, in, 1: exception or ertn flush from WB.
REQ-008 if_allow_in, out, 1: IF can accept a new entry.
REQ-009 if_to_id_valid, out, 1: instruction offered to ID.
REQ-010 if_to_id_pc, out, 32: PC of the offered instruction.
REQ-011 if_to_id_inst, out, 32: the offered instruction word.
REQ-012 if_to_id_ex, out, 1: fetch-address exception (ADEF) flag.

Function
REQ-013 States SHALL be EMPTY, FETCH and HOLD.
- EMPTY: no instruction in IF.
- FETCH: the instruction is on inst_rdata this cycle.
- HOLD: the instruction is held in the internal buffer.
REQ-014 if_allow_in SHALL equal EMPTY || (id_allow_in && !br_taken && !wb_ex).
REQ-015 Acceptance SHALL occur when pre_if_ready_go && if_allow_in && !wb_ex && !br_taken; the next state is then FETCH.
REQ-016 In FETCH with id_allow_in=1, if_to_id_inst SHALL equal inst_rdata combinationally.
- The next state is FETCH if a new instruction was accepted this cycle, else EMPTY.
REQ-017 In FETCH with id_allow_in=0, inst_rdata SHALL be captured into the buffer; the next state is HOLD.
REQ-018 In HOLD, if_to_id_inst SHALL equal the buffer contents.
- The buffer holds until id_allow_in=1.
- Next state: FETCH if a new instruction was accepted, else EMPTY.
REQ-019 if_to_id_valid SHALL be (state!=EMPTY) && !br_taken && !wb_ex.
REQ-020 br_taken or wb_ex SHALL force the next state to EMPTY and clear the buffer, regardless of id_allow_in.
REQ-021 If wb_ex and br_taken occur together, the result SHALL be the same as wb_ex alone.
REQ-022 if_to_id_pc SHALL equal if_pc; the PC register is stalled whenever IF is not advancing.
REQ-023 Latency SHALL be one cycle from acceptance to if_to_id_valid.
- Throughput SHALL be one instruction per cycle while id_allow_in=1.
REQ-024 Outputs SHALL be stable while if_to_id_valid=1 and id_allow_in=0.

Reset
REQ-025 On rst=1 at a clock edge, the block SHALL go to EMPTY and clear the buffer to 32'h0.
REQ-026 While rst=1, if_to_id_valid, if_to_id_inst and if_to_id_ex SHALL all be 0.
REQ-027 Reset asserted mid-HOLD SHALL discard the held instruction; after reset, ID receives nothing until a new acceptance.

Configuration
REQ-028 With IF_ADEF_CHECK_EN defined, a valid instruction with if_pc[1:0]!=2'b00 SHALL set if_to_id_ex=1 and force if_to_id_inst to 32'h0.
- Handshake timing is unchanged.
REQ-029 Without IF_ADEF_CHECK_EN, if_to_id_ex SHALL be tied 0 and no alignment logic SHALL be synthesised.

Structure
REQ-030 The shared package SHALL hold:
- the state encoding (2 bits);
- the IF-to-ID bus width (65 bits: ex, pc, inst);
- the NOP encoding 32'h0.
REQ-031 The instruction buffer (register plus load/clear control) SHALL be sub-module if_inst_buf; the FSM remains in if_stage.

Verification
REQ-032 Steady flow: pre_if_ready_go=1, id_allow_in=1, PCs 0x1c000000, 0x1c000004, 0x1c000008 -> three consecutive valid outputs with matching inst_rdata, no bubbles.
REQ-033 Stall: id_allow_in=0 for 3 cycles in FETCH with inst 0x02800421 -> HOLD, if_allow_in=0, output stays 0x02800421 after inst_rdata changes, and is released on the cycle id_allow_in=1.
REQ-034 Branch flush in HOLD: br_taken=1 for one cycle -> if_to_id_valid=0 that cycle, state EMPTY next cycle, buffer 0.
REQ-035 wb_ex and br_taken together with pre_if_ready_go=1 -> no acceptance, EMPTY next cycle.
REQ-036 IF_ADEF_CHECK_EN defined, if_pc=0x1c000002 -> if_to_id_ex=1, inst 0x0; without the macro -> if_to_id_ex=0.
REQ-037 rst=1 during HOLD -> EMPTY next cycle, all outputs 0, first valid output only after a fresh acceptance.
